// File: rtl/ysyx_25040118_dmem_ctrl.sv
// ysyx_25040118_dmem_ctrl
// Data-memory access controller sitting behind the LSU address/mask logic.
// It takes one load/store at a time over a valid/ready handshake and issues it
// to a variable-latency, word-addressed memory port (req/gnt, then rvalid).
// For loads it returns sign- or zero-extended data to writeback.
//
// Optional feature macro: DMEM_MISALIGN_CHK_EN
//   When defined, a misaligned lh/lhu/sh/lw/sw is answered straight away with
//   resp_err=1 and no memory request is issued.
//   When undefined, misaligned accesses go to memory as-is.
module ysyx_25040118_dmem_ctrl #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          TIMEOUT   = 255,
    parameter int          TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    // LSU request channel
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    input  logic [2:0]  req_funct3_i,
    // writeback response channel
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    // memory port
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;      // physical word address
    logic [1:0]           off_q, off_d;        // byte offset within the word
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wmask_q, wmask_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    // Extract and extend load data from the full memory word.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_extend = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_extend = word;
            3'b100:  load_extend = {24'h00_0000, shifted[7:0]};
            3'b101:  load_extend = {16'h0000, shifted[15:0]};
            default: load_extend = 32'h0000_0000;
        endcase
    endfunction

    // True when funct3 names an access this controller does not support.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            funct3_illegal = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        end else begin
            funct3_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
    endfunction

`ifdef DMEM_MISALIGN_CHK_EN
    // True for a halfword access on an odd address or a word access off a word boundary.
    function automatic logic misaligned(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic half_acc;
        logic word_acc;
        half_acc   = (f3 == 3'b001) || (!we && (f3 == 3'b101));
        word_acc   = (f3 == 3'b010);
        misaligned = (half_acc && off[0]) || (word_acc && (off != 2'b00));
    endfunction
`endif

    // Next-state and next-field logic for the request/response FSM.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        funct3_d = funct3_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    addr_d   = {req_addr_i[31:2], 2'b00} - MEM_BASE;
                    off_d    = req_addr_i[1:0];
                    wdata_d  = req_wdata_i;
                    // loads never write, whatever mask the LSU produced
                    wmask_d  = req_we_i ? req_wmask_i : 4'b0000;
                    funct3_d = req_funct3_i;
                    state_d  = S_REQ;
`ifdef DMEM_MISALIGN_CHK_EN
                    if (misaligned(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else begin
                        state_d = S_REQ;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                    cnt_d   = {TIMEOUT_W{1'b0}};
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                // rvalid on the final counted cycle still wins over the timeout
                if (mem_rvalid_i) begin
                    state_d = S_RESP;
                    err_d   = funct3_illegal(we_q, funct3_q);
                    if (we_q || funct3_illegal(we_q, funct3_q)) begin
                        rdata_d = 32'h0000_0000;
                    end else begin
                        rdata_d = load_extend(funct3_q, off_q, mem_rdata_i);
                    end
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT)) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                    rdata_d = 32'h0000_0000;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
                rdata_d = 32'h0000_0000;
            end
        endcase
    end

    // State, latched request fields, timeout counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= 32'h0000_0000;
            off_q    <= 2'b00;
            wdata_q  <= 32'h0000_0000;
            wmask_q  <= 4'b0000;
            funct3_q <= 3'b000;
            cnt_q    <= {TIMEOUT_W{1'b0}};
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Handshake flags decode directly from the state register.
    assign req_ready_o  = (state_q == S_IDLE);
    assign mem_req_o    = (state_q == S_REQ);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign mem_we_o     = (state_q == S_REQ) && we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wmask_o  = wmask_q;

endmodule

// File: tb/tb_ysyx_25040118_dmem_ctrl.sv
// Self-checking bench for ysyx_25040118_dmem_ctrl: directed transactions, a
// transaction-level expectation model, and a per-cycle compare process.
module tb_ysyx_25040118_dmem_ctrl;

    localparam int TIMEOUT = 255;
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_RESP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [3:0]  req_wmask = 4'h0;
    logic [2:0]  req_funct3 = 3'h0;
    logic        resp_ready = 1'b0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // expectation model state
    int          exp_phase = P_IDLE;
    logic [31:0] exp_maddr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wmask;
    logic        exp_we, exp_err;
    // observations captured on the first resp_valid cycle of a transaction
    int          acc_cyc, rv_cyc, memreq_cnt;
    logic [31:0] last_rdata;
    logic        last_err;
    logic        prev_rv = 1'b0;

    ysyx_25040118_dmem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wmask_i  (req_wmask),
        .req_funct3_i (req_funct3),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wmask_o  (mem_wmask),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load result straight from the funct3 table, using plain arithmetic.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word, output logic err);
        logic [31:0] sh;
        logic [31:0] b;
        int          off;
        off = int'(addr[1:0]);
        sh  = word >> (8 * off);
        err = 1'b0;
        case (f3)
            3'd0: begin b = sh % 32'd256;   return (b >= 32'd128)   ? b - 32'd256   : b; end
            3'd1: begin b = sh % 32'd65536; return (b >= 32'd32768) ? b - 32'd65536 : b; end
            3'd2: return word;
            3'd4: return sh % 32'd256;
            3'd5: return sh % 32'd65536;
            default: begin err = 1'b1; return 32'd0; end
        endcase
    endfunction

    function automatic bit model_misaligned(input logic we, input logic [2:0] f3, input logic [31:0] addr);
`ifdef DMEM_MISALIGN_CHK_EN
        if ((f3 == 3'd1 || (!we && f3 == 3'd5)) && (addr % 32'd2 != 32'd0)) return 1'b1;
        if (f3 == 3'd2 && (addr % 32'd4 != 32'd0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Per-cycle comparison of DUT outputs against the expected phase and fields.
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, exp_phase == P_IDLE});
            chk("mem_req", {31'd0, mem_req}, {31'd0, exp_phase == P_REQ});
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_phase == P_RESP});
            if (mem_req) memreq_cnt++;
            if (exp_phase == P_REQ) begin
                chk("mem_addr", mem_addr, exp_maddr);
                chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
                chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_phase == P_RESP) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
            end else begin
                chk("resp_rdata_idle", resp_rdata, 32'd0);
                chk("resp_err_idle", {31'd0, resp_err}, 32'd0);
            end
            if (resp_valid && !prev_rv) begin
                rv_cyc     = cyc;
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
            prev_rv = resp_valid;
        end
    end

    // One complete transaction. rv_dly < 0 means memory never answers.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic [2:0] f3, input logic [31:0] rdata,
                           input int gnt_dly, input int rv_dly, input int rdy_dly, input bit stale);
        logic lerr;
        logic [31:0] lval;
        bit mis;
        mis        = model_misaligned(we, f3, addr);
        exp_maddr  = (addr - (addr % 32'd4)) - 32'h8000_0000;
        exp_we     = we;
        exp_wmask  = we ? wmask : 4'd0;
        exp_wdata  = wdata;
        lval       = model_load(f3, addr, rdata, lerr);
        if (mis || rv_dly < 0) begin
            exp_err = 1'b1; exp_rdata = 32'd0;
        end else if (we) begin
            exp_err = (f3 > 3'd2); exp_rdata = 32'd0;
        end else begin
            exp_err = lerr; exp_rdata = lval;
        end
        memreq_cnt = 0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = wmask; req_funct3 = f3;
        req_valid = 1'b1;
        acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (mis) begin
            exp_phase = P_RESP;
        end else begin
            exp_phase = P_REQ;
            repeat (gnt_dly) begin @(posedge clk); #1; end
            mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            exp_phase = P_WAIT;
            if (rv_dly < 0) begin
                repeat (TIMEOUT + 1) begin @(posedge clk); #1; end
            end else begin
                repeat (rv_dly) begin @(posedge clk); #1; end
                mem_rvalid = 1'b1; mem_rdata = rdata;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
            exp_phase = P_RESP;
        end
        if (stale) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
        repeat (rdy_dly) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_phase = P_IDLE;
        if (stale) begin @(posedge clk); #1; mem_rvalid = 1'b0; end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        @(posedge clk); #1;
        chk_en = 1'b1;

        // lb, sign bit set, zero-latency memory
        run_txn(1'b0, 32'h8000_0003, 32'h0, 4'hF, 3'd0, 32'h80FF_1234, 0, 0, 0, 1'b0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        chk("lb_latency", 32'(rv_cyc - acc_cyc), 32'd3);
        // sh with delayed grant
        run_txn(1'b1, 32'h8000_0102, 32'hBEEF_0000, 4'b1100, 3'd1, 32'h0, 2, 0, 0, 1'b0);
        chk("sh_memreq_cycles", 32'(memreq_cnt), 32'd3);
        chk("sh_err", {31'd0, last_err}, 32'd0);
        chk("sh_rdata", last_rdata, 32'd0);
        // lhu with a stalled consumer
        run_txn(1'b0, 32'h8000_0002, 32'h0, 4'h0, 3'd5, 32'h9ABC_0000, 0, 0, 4, 1'b0);
        chk("lhu_rdata", last_rdata, 32'h0000_9ABC);
        // lw timeout, then stale rvalid
        run_txn(1'b0, 32'h8000_0040, 32'h0, 4'h0, 3'd2, 32'h1234_5678, 0, -1, 2, 1'b1);
        chk("to_err", {31'd0, last_err}, 32'd1);
        chk("to_rdata", last_rdata, 32'd0);
        // rvalid on the last counted cycle is a success
        run_txn(1'b0, 32'h8000_0044, 32'h0, 4'h0, 3'd2, 32'h1234_5678, 1, TIMEOUT, 0, 1'b0);
        chk("edge_err", {31'd0, last_err}, 32'd0);
        chk("edge_rdata", last_rdata, 32'h1234_5678);
        // misaligned lw
        run_txn(1'b0, 32'h8000_0001, 32'h0, 4'h0, 3'd2, 32'h1122_3344, 0, 0, 0, 1'b0);
`ifdef DMEM_MISALIGN_CHK_EN
        chk("mis_err", {31'd0, last_err}, 32'd1);
        chk("mis_memreq_cycles", 32'(memreq_cnt), 32'd0);
        chk("mis_latency", 32'(rv_cyc - acc_cyc), 32'd1);
`else
        chk("mis_rdata", last_rdata, 32'h1122_3344);
        chk("mis_memreq_cycles", 32'(memreq_cnt), 32'd1);
`endif
        // further extension cases, back to back
        run_txn(1'b0, 32'h8000_0202, 32'h0, 4'hF, 3'd1, 32'h8001_7FFF, 0, 1, 0, 1'b0);
        chk("lh_rdata", last_rdata, 32'hFFFF_8001);
        run_txn(1'b0, 32'h8000_0201, 32'h0, 4'h0, 3'd4, 32'h0000_F000, 0, 0, 0, 1'b0);
        chk("lbu_rdata", last_rdata, 32'h0000_00F0);
        run_txn(1'b0, 32'h8000_0300, 32'h0, 4'h0, 3'd3, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
        chk("ill_ld_err", {31'd0, last_err}, 32'd1);
        run_txn(1'b1, 32'h8000_0304, 32'hCAFE_F00D, 4'hF, 3'd3, 32'h0, 0, 3, 1, 1'b0);
        chk("ill_st_err", {31'd0, last_err}, 32'd1);
        run_txn(1'b1, 32'h8000_0308, 32'hCAFE_F00D, 4'hF, 3'd2, 32'h0, 0, 0, 0, 1'b0);
        chk("sw_err", {31'd0, last_err}, 32'd0);

        // reset in the middle of WAIT, then a late rvalid
        exp_maddr = 32'h10; exp_we = 1'b0; exp_wmask = 4'h0; exp_wdata = 32'h0;
        req_we = 1'b0; req_addr = 32'h8000_0010; req_wdata = 32'h0; req_funct3 = 3'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; exp_phase = P_REQ; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; exp_phase = P_WAIT;
        @(posedge clk); #1;
        rst = 1'b1; exp_phase = P_IDLE;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstw_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
